mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 32-bit RISC-V pipeline. It sits between the EX stage and the WB stage.
- It performs loads and stores over a request/acknowledge data-memory bus and formats load data (byte/half/word, sign or zero extension).
- It holds the MEM/WB pipeline register that drives the WB stage inputs: ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb.
- It stalls upstream while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles to wait for dmem_ack before aborting. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX/MEM slot holds a valid instruction
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign
- ex_alu_result  in  32  ALU result / effective address
- ex_store_data  in  32  rs2 value for stores
- ex_pc4  in  32  PC+4
- ex_rd  in  32  destination register index
- ex_ctrl_wb  in  3  [0]=reg write enable, [2:1]=WB mux select
- mem_stall  out  1  hold EX/MEM and earlier stages
- dmem_req  out  1  bus request
- dmem_we  out  1  1=write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  transaction complete; dmem_rdata valid this cycle
- dmem_rdata  in  32  read word
- ctrl_wb  out  3  to WB
- pc4_wb  out  32  to WB
- mem_data  out  32  formatted load data
- alu_data  out  32  to WB
- rd_wb  out  32  to WB
- mem_err  out  1  one-cycle pulse, aligned with the faulting instruction in MEM/WB

Behaviour:
Reset
- Synchronous active-high reset; rst is checked every rising clk edge.
- On reset: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr/wdata/be=0, all MEM/WB outputs=0, mem_err=0, timeout counter=0.
- Reset asserted mid-transaction aborts it. An ack arriving afterwards is ignored.

Definitions
- memop = ex_valid & (ex_mem_read | ex_mem_write).
- Legal loads (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores (funct3): 000 SB, 001 SH, 010 SW.
- err_op = memop and any of: illegal funct3; half access with addr[0]=1; word access with addr[1:0]!=0.

FSM with states IDLE and BUSY
- IDLE, memop & !err_op:
  - Register the bus request: dmem_req<=1, dmem_we<=ex_mem_write, dmem_addr<={addr[31:2],2'b00}.
  - Byte enables: SB gives 1<<addr[1:0]; SH gives 0011 or 1100 by addr[1]; SW gives 1111.
  - Write data: SB replicates byte x4, SH replicates half x2, SW passes the word.
  - Latch load-format info (funct3, addr[1:0]); go to BUSY.
- BUSY:
  - dmem_req and all bus outputs stay stable until dmem_ack.
  - On dmem_ack: dmem_req<=0, return to IDLE, MEM/WB captures the instruction. For loads, mem_data = formatted dmem_rdata; for stores, mem_data=0.
- dmem_ack while in IDLE is ignored.

Stall
- mem_stall (combinational) = (IDLE & memop & !err_op) | (BUSY & !dmem_ack).
- A load/store therefore occupies at least 2 cycles; ack in the first BUSY cycle gives the minimum.

MEM/WB register
- Loads every edge.
- When mem_stall=1 it loads a bubble: ctrl_wb=0, other fields hold.
- Otherwise it loads ex_* fields; if ex_valid=0, ctrl_wb=0.
- Non-memory instructions pass in 1 cycle with mem_data=0.

Load formatting
- Select byte/half by the latched addr[1:0] (byte) or addr[1] (half).
- LB/LH sign-extend; LBU/LHU zero-extend.

err_op
- No bus request, no stall; the instruction passes in 1 cycle.
- ctrl_wb[0] is forced 0 and mem_err=1 with that MEM/WB entry.

Timeout (TIMEOUT_CYCLES>0)
- A 16-bit counter increments each BUSY cycle without ack.
- When count reaches TIMEOUT_CYCLES: dmem_req<=0, IDLE, MEM/WB captures the instruction with ctrl_wb[0]=0 and mem_err=1, and mem_stall drops that cycle.
- Counter clears on entering IDLE.
- Ack on the timeout cycle counts as a normal completion.

Test Plan:
- ALU op (ex_alu_result=0x1234, ctrl_wb=001, rd=5) with no memop -> next cycle alu_data=0x1234, ctrl_wb=001, rd_wb=5, mem_stall never 1.
- LB at addr 0x103, ack after 3 BUSY cycles with rdata=0x80FF_FF_FF:
  - dmem_addr=0x100 held stable; mem_stall high 4 cycles.
  - MEM/WB then shows mem_data=0xFFFFFF80, ctrl_wb=011; bubbles (ctrl_wb=000) appear during the stall.
- SH at addr 0x202 with store_data=0xABCD1234 -> dmem_we=1, be=1100, wdata=0x12341234; one-cycle ack -> 2-cycle op, mem_data=0.
- LW at addr 0x101 -> no dmem_req, mem_err=1 next cycle, ctrl_wb[0]=0, no stall. funct3=011 load gives the same response.
- TIMEOUT_CYCLES=4, LHU with no ack -> dmem_req drops after 4 BUSY cycles, mem_err=1, ctrl_wb[0]=0. A later stray ack is ignored.
- rst during BUSY -> next cycle all outputs 0, state IDLE. After release, a new LW issues normally.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V MEM stage: data-memory access, load formatting, MEM/WB register
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] ex_rd,
    input  logic [2:0]  ex_ctrl_wb,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [2:0]  ctrl_wb,
    output logic [31:0] pc4_wb,
    output logic [31:0] mem_data,
    output logic [31:0] alu_data,
    output logic [31:0] rd_wb,
    output logic        mem_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        memop, f3_legal, misaligned, err_op;
    logic        issue, timeout_hit, wb_err;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic        lat_read;
    logic [15:0] to_cnt;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_fmt;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        memop = ex_valid & (ex_mem_read | ex_mem_write);
        if (ex_mem_read)
            f3_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            f3_legal = ex_funct3 inside {3'b000, 3'b001, 3'b010};
        case (ex_funct3[1:0])
            2'b01:   misaligned = ex_alu_result[0];
            2'b10:   misaligned = (ex_alu_result[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        err_op = memop & (~f3_legal | misaligned);
    end

    // Timeout fires on the TIMEOUT_CYCLES-th BUSY cycle; an ack in that same cycle wins.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !dmem_ack && (to_cnt == TO_LAST);
        issue       = (state == IDLE) & memop & ~err_op;
        mem_stall   = issue | ((state == BUSY) & ~dmem_ack & ~timeout_hit);
        wb_err      = ((state == IDLE) & err_op) | timeout_hit;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = BUSY;
            BUSY:    if (dmem_ack || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << ex_alu_result[1:0];
                wdata_next = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                be_next    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{ex_store_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = ex_store_data;
            end
        endcase
    end

    always_comb begin
        case (lat_off)
            2'd0:    sel_byte = dmem_rdata[7:0];
            2'd1:    sel_byte = dmem_rdata[15:8];
            2'd2:    sel_byte = dmem_rdata[23:16];
            default: sel_byte = dmem_rdata[31:24];
        endcase
        sel_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_funct3)
            3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_fmt = {24'd0, sel_byte};
            3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_fmt = {16'd0, sel_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            lat_funct3 <= 3'd0;
            lat_off    <= 2'd0;
            lat_read   <= 1'b0;
            to_cnt     <= 16'd0;
            ctrl_wb    <= 3'd0;
            pc4_wb     <= 32'd0;
            mem_data   <= 32'd0;
            alu_data   <= 32'd0;
            rd_wb      <= 32'd0;
            mem_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ex_mem_write;
                dmem_addr  <= {ex_alu_result[31:2], 2'b00};
                dmem_be    <= be_next;
                dmem_wdata <= wdata_next;
                lat_funct3 <= ex_funct3;
                lat_off    <= ex_alu_result[1:0];
                lat_read   <= ex_mem_read;
            end else if (state_next == IDLE) begin
                dmem_req <= 1'b0;
            end
            if (state == BUSY && state_next == BUSY)
                to_cnt <= to_cnt + 16'd1;
            else
                to_cnt <= 16'd0;
            // EX/MEM is held while stalled, so on completion ex_* still describes the access.
            if (mem_stall) begin
                ctrl_wb <= 3'd0;
                mem_err <= 1'b0;
            end else begin
                ctrl_wb  <= ex_valid ? {ex_ctrl_wb[2:1], ex_ctrl_wb[0] & ~wb_err} : 3'd0;
                pc4_wb   <= ex_pc4;
                alu_data <= ex_alu_result;
                rd_wb    <= ex_rd;
                mem_data <= (state == BUSY && dmem_ack && lat_read) ? load_fmt : 32'd0;
                mem_err  <= wb_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural access model
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_store_data, ex_pc4, ex_rd;
    logic [2:0]  ex_ctrl_wb;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [2:0]  ctrl_wb;
    logic [31:0] pc4_wb, mem_data, alu_data, rd_wb;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_pc4(ex_pc4), .ex_rd(ex_rd), .ex_ctrl_wb(ex_ctrl_wb),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .ctrl_wb(ctrl_wb), .pc4_wb(pc4_wb), .mem_data(mem_data),
        .alu_data(alu_data), .rd_wb(rd_wb), .mem_err(mem_err)
    );

    function automatic bit model_legal(bit is_load, int f3, logic [31:0] addr);
        int size;
        size = f3 % 4;
        if (is_load) begin
            if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 0;
        end else begin
            if (f3 > 2) return 0;
        end
        return (addr % (32'd1 << size)) == 0;
    endfunction

    function automatic logic [3:0] model_be(int f3, logic [31:0] addr);
        if (f3 % 4 == 0) return 4'(1 << (addr % 4));
        if (f3 % 4 == 1) return 4'(3 << (addr % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(int f3, logic [31:0] sd);
        if (f3 % 4 == 0) return (sd % 256) * 32'h0101_0101;
        if (f3 % 4 == 1) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(int f3, logic [31:0] addr, logic [31:0] rdata);
        logic [31:0] v;
        if (f3 % 4 == 0) begin
            v = (rdata >> (8 * (addr % 4))) % 256;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (f3 % 4 == 1) begin
            v = (rdata >> (16 * ((addr % 4) / 2))) % 65536;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic do_op(input bit valid, input bit rd_i, input bit wr_i, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] pc4,
                         input logic [31:0] rdx, input logic [2:0] ctrl, input int ack_delay,
                         input logic [31:0] rdata);
        bit          memop, legal, go;
        logic [2:0]  exp_ctrl;
        logic [31:0] exp_md;
        ex_valid = valid; ex_mem_read = rd_i; ex_mem_write = wr_i; ex_funct3 = f3;
        ex_alu_result = addr; ex_store_data = sd; ex_pc4 = pc4; ex_rd = rdx; ex_ctrl_wb = ctrl;
        memop = valid && (rd_i || wr_i);
        legal = model_legal(rd_i, int'(f3), addr);
        go    = memop && legal;
        #1;
        n_checks++;
        if (mem_stall !== go) begin n_fail++; $display("FAIL stall_issue: got %b expected %b", mem_stall, go); end
        if (go) begin
            for (int i = 0; i <= ack_delay; i++) begin
                @(posedge clk); #1;
                n_checks++;
                if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL busy_req: got %b expected 1", dmem_req); end
                n_checks++;
                if (dmem_we !== wr_i) begin n_fail++; $display("FAIL busy_we: got %b expected %b", dmem_we, wr_i); end
                n_checks++;
                if (dmem_addr !== addr - addr % 4) begin n_fail++; $display("FAIL busy_addr: got %h expected %h", dmem_addr, addr - addr % 4); end
                n_checks++;
                if (ctrl_wb !== 3'b000) begin n_fail++; $display("FAIL bubble_ctrl: got %b expected 000", ctrl_wb); end
                if (wr_i) begin
                    n_checks++;
                    if (dmem_be !== model_be(int'(f3), addr)) begin n_fail++; $display("FAIL busy_be: got %b expected %b", dmem_be, model_be(int'(f3), addr)); end
                    n_checks++;
                    if (dmem_wdata !== model_wdata(int'(f3), sd)) begin n_fail++; $display("FAIL busy_wdata: got %h expected %h", dmem_wdata, model_wdata(int'(f3), sd)); end
                end
                dmem_ack   = (i == ack_delay);
                dmem_rdata = (i == ack_delay) ? rdata : $urandom;
                #1;
                n_checks++;
                if (mem_stall !== (i != ack_delay)) begin n_fail++; $display("FAIL busy_stall: got %b expected %b", mem_stall, i != ack_delay); end
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        exp_ctrl = !valid ? 3'b000 : (memop && !legal) ? (ctrl & 3'b110) : ctrl;
        exp_md   = (go && rd_i) ? model_load(int'(f3), addr, rdata) : 32'd0;
        n_checks++;
        if (ctrl_wb !== exp_ctrl) begin n_fail++; $display("FAIL wb_ctrl: got %b expected %b", ctrl_wb, exp_ctrl); end
        n_checks++;
        if (mem_data !== exp_md) begin n_fail++; $display("FAIL wb_mem_data: got %h expected %h", mem_data, exp_md); end
        n_checks++;
        if (mem_err !== (memop && !legal)) begin n_fail++; $display("FAIL wb_err: got %b expected %b", mem_err, memop && !legal); end
        n_checks++;
        if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL req_after: got %b expected 0", dmem_req); end
        n_checks++;
        if ({alu_data, pc4_wb, rd_wb} !== {addr, pc4, rdx}) begin
            n_fail++; $display("FAIL wb_fields: got %h/%h/%h expected %h/%h/%h", alu_data, pc4_wb, rd_wb, addr, pc4, rdx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
        ex_alu_result = 0; ex_store_data = 0; ex_pc4 = 0; ex_rd = 0; ex_ctrl_wb = 0;
        dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== 70'd0) begin
            n_fail++; $display("FAIL reset_bus: got %b/%b/%h/%h/%b expected zeros", dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be);
        end
        n_checks++;
        if ({ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb, mem_err, mem_stall} !== 133'd0) begin
            n_fail++; $display("FAIL reset_wb: got %b/%h/%h/%h/%h/%b/%b expected zeros", ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb, mem_err, mem_stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        do_op(1, 0, 0, 3'b000, 32'h1234, 32'h0, 32'h44, 32'd5, 3'b001, 0, 32'h0);
    endtask

    task automatic test_lb_slow();
        do_op(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h48, 32'd7, 3'b011, 3, 32'h80FF_FFFF);
        n_checks++;
        if (mem_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_value: got %h expected ffffff80", mem_data); end
    endtask

    task automatic test_sh();
        do_op(1, 0, 1, 3'b001, 32'h202, 32'hABCD_1234, 32'h4C, 32'd0, 3'b000, 0, 32'h0);
    endtask

    task automatic test_err_ops();
        do_op(1, 1, 0, 3'b010, 32'h101, 32'h0, 32'h50, 32'd9, 3'b011, 0, 32'h0);
        do_op(1, 1, 0, 3'b011, 32'h100, 32'h0, 32'h54, 32'd9, 3'b011, 0, 32'h0);
        do_op(1, 0, 1, 3'b001, 32'h203, 32'h5, 32'h58, 32'd0, 3'b000, 0, 32'h0);
    endtask

    task automatic test_timeout();
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b101;
        ex_alu_result = 32'h300; ex_pc4 = 32'h60; ex_rd = 32'd3; ex_ctrl_wb = 3'b011;
        dmem_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL to_req: got %b expected 1", dmem_req); end
            n_checks++;
            if (mem_stall !== (i < 3)) begin n_fail++; $display("FAIL to_stall: got %b expected %b", mem_stall, i < 3); end
        end
        @(posedge clk); #1;
        n_checks++;
        if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b expected 0", dmem_req); end
        n_checks++;
        if ({mem_err, ctrl_wb, mem_data} !== {1'b1, 3'b010, 32'd0}) begin
            n_fail++; $display("FAIL to_wb: got err=%b ctrl=%b data=%h expected err=1 ctrl=010 data=0", mem_err, ctrl_wb, mem_data);
        end
        ex_valid = 0; dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL stray_stall: got %b expected 0", mem_stall); end
        @(posedge clk); #1;
        dmem_ack = 0;
        n_checks++;
        if ({dmem_req, ctrl_wb, mem_err, mem_data} !== 37'd0) begin
            n_fail++; $display("FAIL stray_ack: got req=%b ctrl=%b err=%b data=%h expected zeros", dmem_req, ctrl_wb, mem_err, mem_data);
        end
    endtask

    task automatic test_reset_busy();
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        ex_alu_result = 32'h400; ex_pc4 = 32'h64; ex_rd = 32'd4; ex_ctrl_wb = 3'b011;
        @(posedge clk); #1;
        n_checks++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rb_req: got %b expected 1", dmem_req); end
        rst = 1; ex_valid = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb, mem_err} !== 202'd0) begin
            n_fail++; $display("FAIL rb_outputs: got req=%b addr=%h ctrl=%b pc4=%h alu=%h err=%b expected zeros", dmem_req, dmem_addr, ctrl_wb, pc4_wb, alu_data, mem_err);
        end
        rst = 0; dmem_ack = 1;
        @(posedge clk); #1;
        dmem_ack = 0;
        n_checks++;
        if ({dmem_req, mem_stall, ctrl_wb} !== 5'd0) begin
            n_fail++; $display("FAIL rb_late_ack: got req=%b stall=%b ctrl=%b expected zeros", dmem_req, mem_stall, ctrl_wb);
        end
        do_op(1, 1, 0, 3'b010, 32'h404, 32'h0, 32'h68, 32'd6, 3'b011, 1, 32'h1357_9BDF);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            int          kind;
            bit          v, r, w;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            v = (kind != 3);
            r = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
            w = (kind == 2) || (kind == 3 && !r);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            do_op(v, r, w, 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom,
                  3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom);
        end
        ex_valid = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_slow();
        test_sh();
        test_err_ops();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
